round_robin_sel_gen: RTL and testbench
======================================

ROUND_ROBIN_SEL_GEN -- requirements
Module: round_robin_sel_gen

Interface
REQ-001 SHALL have parameter WIDTH_I, default 2, number of lanes of the downstream AND-array mux (legal range >= 1).
REQ-002 SHALL have parameter HOLD, default 4, maximum cycles one grant stays asserted (legal range >= 1).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  WIDTH_I  per-lane request for mux selection.
REQ-006 SHALL have port done  input  1  early release of the current grant.
REQ-007 SHALL have port sel  output  WIDTH_I  registered one-hot or all-zero mask that drives the AND-array x input.
REQ-008 SHALL have port active  output  1  high exactly when sel is non-zero.
REQ-009 SHALL have port sel_idx  output  max($clog2(WIDTH_I),1)  binary index of the granted lane, 0 when idle.

Function
REQ-010 SHALL implement states IDLE, GRANT, GAP; sel is non-zero only in GRANT.
REQ-011 SHALL arbitrate round-robin: the winner is the first lane with req=1, searching from pointer ptr upward with wrap from WIDTH_I-1 to 0.
REQ-012 SHALL register the grant: req sampled at edge N gives sel at edge N+1 (1-cycle latency), with no combinational path from req to sel.
REQ-013 IDLE: sel=0; if req!=0, load winner into sel and go to GRANT; otherwise stay.
REQ-014 GRANT: hold counter starts at 0 on entry and increments each cycle; the grant is released when done=1, counter==HOLD-1, or req[sel_idx]==0.
REQ-015 Simultaneous release causes (done with expiry, done with req drop) SHALL produce a single release.
REQ-016 On release, ptr SHALL load (sel_idx+1) mod WIDTH_I.
REQ-017 Without the gap feature, release SHALL re-arbitrate in the same edge using the updated ptr: grant the next winner back-to-back, or go to IDLE if req==0.
REQ-018 A lane still requesting alone SHALL be re-granted after release, with a fresh hold count.
REQ-019 sel SHALL never have more than one bit set in any cycle.
REQ-020 WIDTH_I=1 SHALL degenerate to lane 0 only; ptr stays 0.

Reset
REQ-021 While rst=1 at an edge: state=IDLE, sel=0, active=0, sel_idx=0, ptr=0, counter=0.
REQ-022 rst asserted mid-GRANT SHALL clear sel at that same edge, and no partial hold count is retained.
REQ-023 The first grant after reset release SHALL come from lane 0 search order.

Configuration
REQ-024 Macro SEL_GAP_EN SHALL enable break-before-make behaviour.
REQ-025 With SEL_GAP_EN defined, every release SHALL go to GAP for exactly one cycle with sel=0, then to IDLE for arbitration.
  - Consequence: minimum two zero cycles between consecutive grants (GAP plus the IDLE evaluation edge).
REQ-026 Without SEL_GAP_EN, state GAP SHALL be unreachable, and back-to-back grants follow REQ-017.

Verification (WIDTH_I=2, HOLD=4 unless stated)
REQ-027 Reset: rst=1 for 2 cycles with req=2'b11 -> sel=2'b00 and active=0 throughout; first edge after release -> sel=2'b01, sel_idx=0.
REQ-028 Rotation, no macro: req=2'b11 held, done=0 -> sel=01 for 4 cycles, then 10 for 4 cycles, then 01 again, with no zero cycles.
REQ-029 Rotation, SEL_GAP_EN: same stimulus -> sel 01x4, 00x2, 10x4, 00x2, 01.
REQ-030 Early release: req=2'b10, done=1 in the 2nd grant cycle -> sel=10 for 2 cycles, then re-grant 10 with the counter restarted (no macro).
REQ-031 Request drop: req 01 -> 00 during grant cycle 2 -> sel=00 and active=0 at the next edge, and state is IDLE.
REQ-032 Reset mid-grant: rst=1 during the 3rd cycle of sel=10 -> sel=00 at that edge; after release with req=11 -> sel=01 (ptr cleared).

Source files
------------

// File: rtl/round_robin_sel_gen.sv
// round_robin_sel_gen
//   Round-robin grant generator producing a registered one-hot select mask
//   for a downstream AND-array mux. A grant is held for at most HOLD cycles
//   and is released early by done or by the granted lane dropping its request.
//   On release the pointer moves past the released lane and arbitration runs
//   again in the same edge, so grants can follow each other back-to-back.
//
//   Optional feature macro SEL_GAP_EN: break-before-make. Each release passes
//   through one GAP cycle and then one IDLE cycle, both with sel = 0, before
//   the next grant is issued.
//
// Parameters
//   WIDTH_I  number of mux lanes (>= 1)
//   HOLD     maximum number of cycles a grant stays asserted (>= 1)
// Ports
//   clk      clock, all state updates on the rising edge
//   rst      synchronous active-high reset
//   req      per-lane request
//   done     early release of the current grant
//   sel      registered one-hot or all-zero select mask
//   active   high exactly when sel is non-zero
//   sel_idx  binary index of the granted lane, 0 when idle
module round_robin_sel_gen #(
  parameter int unsigned WIDTH_I = 2,
  parameter int unsigned HOLD    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [WIDTH_I-1:0]                   req,
  input  logic                                 done,
  output logic [WIDTH_I-1:0]                   sel,
  output logic                                 active,
  output logic [((WIDTH_I > 1) ? $clog2(WIDTH_I) : 1)-1:0] sel_idx
);

  localparam int unsigned IW = (WIDTH_I > 1) ? $clog2(WIDTH_I) : 1;
  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [IW-1:0] LAST_LANE = IW'(WIDTH_I - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     ptr, ptr_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [WIDTH_I-1:0] sel_n;
  logic [IW-1:0]     idx_n;

  logic              release_now;
  logic [IW-1:0]     ptr_rel;
  logic [IW-1:0]     arb_ptr;
  logic [2*WIDTH_I-1:0] rot;
  logic              found;
  int unsigned       win_tmp;
  logic [IW-1:0]     win_idx;
  logic [WIDTH_I-1:0] win_onehot;

  // sel is one-hot at sel_idx, so masking req with sel checks req[sel_idx]
  // without an index that could exceed req's range when WIDTH_I = 1.
  always_comb begin
    release_now = (state == GRANT) &&
                  (done || (cnt == HOLD_LAST) || ((req & sel) == '0));
    ptr_rel     = (sel_idx == LAST_LANE) ? '0 : sel_idx + IW'(1);
    // On release the search must already start from the advanced pointer.
    arb_ptr     = release_now ? ptr_rel : ptr;
  end

  // Rotate a doubled copy of req so bit 0 is the lane at arb_ptr; the first
  // set bit j then maps back to lane (arb_ptr + j) mod WIDTH_I.
  always_comb begin
    rot        = {req, req} >> arb_ptr;
    found      = 1'b0;
    win_tmp    = 0;
    win_idx    = '0;
    for (int unsigned j = 0; j < WIDTH_I; j++) begin
      if (!found && rot[j]) begin
        found   = 1'b1;
        win_tmp = 32'(arb_ptr) + j;
        if (win_tmp >= WIDTH_I) win_tmp = win_tmp - WIDTH_I;
        win_idx = IW'(win_tmp);
      end
    end
    win_onehot = WIDTH_I'(1) << win_idx;
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    idx_n   = sel_idx;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        sel_n = '0;
        idx_n = '0;
        cnt_n = '0;
        if (found) begin
          state_n = GRANT;
          sel_n   = win_onehot;
          idx_n   = win_idx;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_n = ptr_rel;
          cnt_n = '0;
`ifdef SEL_GAP_EN
          state_n = GAP;
          sel_n   = '0;
          idx_n   = '0;
`else
          if (found) begin
            state_n = GRANT;
            sel_n   = win_onehot;
            idx_n   = win_idx;
          end else begin
            state_n = IDLE;
            sel_n   = '0;
            idx_n   = '0;
          end
`endif
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAP: begin
        state_n = IDLE;
        sel_n   = '0;
        idx_n   = '0;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        sel_n   = '0;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      sel_idx <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      sel     <= sel_n;
      sel_idx <= idx_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
    end
  end

  assign active = |sel;

endmodule

// File: tb/tb_round_robin_sel_gen.sv
module tb_round_robin_sel_gen;

  localparam int W  = 2;
  localparam int H  = 4;
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  req;
  logic          done;
  logic [W-1:0]  sel;
  logic          active;
  logic [IW-1:0] sel_idx;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: granted lane (-1 = none), cycles held so far,
  // search start lane, and zero cycles still owed after a break-before-make.
  int m_lane = -1;
  int m_cnt  = 0;
  int m_ptr  = 0;
  int m_wait = 0;

  round_robin_sel_gen #(.WIDTH_I(W), .HOLD(H)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .active  (active),
    .sel_idx (sel_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [W-1:0] r, input int from);
    for (int k = 0; k < W; k++) begin
      if (r[(from + k) % W]) return (from + k) % W;
    end
    return -1;
  endfunction

  task automatic model_edge();
    bit rel;
    if (rst) begin
      m_lane = -1; m_cnt = 0; m_ptr = 0; m_wait = 0;
    end else if (m_lane >= 0) begin
      rel = done || (m_cnt == H - 1) || !req[m_lane];
      if (rel) begin
        m_ptr = (m_lane + 1) % W;
        m_cnt = 0;
`ifdef SEL_GAP_EN
        m_lane = -1;
        m_wait = 1;
`else
        m_lane = pick(req, m_ptr);
`endif
      end else begin
        m_cnt++;
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else begin
      m_lane = pick(req, m_ptr);
      m_cnt  = 0;
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] q, input logic d);
    logic [W-1:0] exp_sel;
    @(negedge clk);
    rst = r; req = q; done = d;
    @(posedge clk);
    model_edge();
    #1;
    exp_sel = (m_lane < 0) ? '0 : W'(1) << m_lane;
    chk("sel", 32'(sel), 32'(exp_sel));
    chk("sel_idx", 32'(sel_idx), (m_lane < 0) ? 0 : 32'(m_lane));
    chk("active", 32'(active), 32'(m_lane >= 0));
    chk("onehot", 32'($countones(sel) <= 1), 1);
  endtask

`ifdef SEL_GAP_EN
  int rot_tab[13] = '{1, 1, 1, 1, 0, 0, 2, 2, 2, 2, 0, 0, 1};
`else
  int rot_tab[13] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1, 2};
`endif

  initial begin
    rst = 1'b1; req = '0; done = 1'b0;

    // Reset held with both lanes requesting, then rotation with no done.
    step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 2'b11, 1'b0);
      chk("rotation", 32'(sel), 32'(rot_tab[i]));
    end

    // Early release by done in the second grant cycle of lane 1.
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b10, 1'b0);
    step(1'b0, 2'b10, 1'b0);
    step(1'b0, 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 2'b10, 1'b0);

    // Request drop during the second grant cycle.
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b01, 1'b0);
    step(1'b0, 2'b01, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    chk("drop_idle", 32'(sel), 0);

    // Reset in the third cycle of a lane-1 grant, then both lanes request.
    step(1'b1, 2'b00, 1'b0);
    step(1'b0, 2'b10, 1'b0);
    step(1'b0, 2'b10, 1'b0);
    step(1'b0, 2'b10, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    chk("rst_mid", 32'(sel), 0);
    step(1'b0, 2'b11, 1'b0);
    chk("rst_ptr", 32'(sel), 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), W'($urandom), ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
